pipe_link: RTL and testbench

- Parametrised inter-stage pipeline buffer for the in-order LoongArch core. It replaces the single-entry stage register and its hand-written valid/allowin/cancel logic.
- Holds up to DEPTH in-flight stage payloads as a circular queue. The head entry is the consumer stage's current instruction.
- Supports branch-cancel flush and optional registered allowin to cut the combinational allowin chain.
- Counts producer stall cycles for performance debug.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_link_sat_counter.sv | 20 ++
 rtl/pipe_link.sv | 89 ++++++++
 tb/tb_pipe_link.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for every pipe_link instance in the core.
// Holds the per-stage payload widths and the circular-pointer arithmetic.
package pipe_pkg;

   localparam int MAX_DEPTH = 8;

   localparam int IF_ID_W   = 64;
   localparam int ID_EXE_W  = 158;
   localparam int EXE_MEM_W = 71;
   localparam int MEM_WB_W  = 70;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Pointers wrap at DEPTH, so non-power-of-two depths stay in range.
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/pipe_link_sat_counter.sv
// Saturating event counter for performance debug; it holds at all-ones and
// never wraps. Only the asynchronous reset clears it.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_link.sv
// Inter-stage pipeline buffer: a DEPTH-entry circular queue whose head is the
// consumer stage's current instruction. It supports flush and registered allowin.
module pipe_link
   import pipe_pkg::*;
#(
   parameter int WIDTH       = 64,
   parameter int DEPTH       = 2,
   parameter int ALLOWIN_REG = 1,
   parameter int CNT_W       = 16
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         flush,
   input  logic                         prod_readygo,
   input  logic                         prod_valid,
   input  logic [WIDTH-1:0]             prod_signal,
   output logic                         link_allowin,
   output logic                         cons_valid,
   output logic [WIDTH-1:0]             cons_signal,
   input  logic                         cons_pop,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int PW = ptr_width(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   localparam logic [OW-1:0] FULL = OW'(DEPTH);

   if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("pipe_link: DEPTH out of range");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_next;
   logic [PW-1:0]    wr_inc;
   logic [OW-1:0]    count;
   logic             pop;
   logic             push;
   logic             has_room;
   logic             stall;

   assign has_room     = count < FULL;
   assign cons_valid   = count != '0;
   assign pop          = cons_pop & cons_valid;
   assign link_allowin = resetn & (has_room | ((ALLOWIN_REG == 0) && pop));
   assign push         = prod_readygo & prod_valid & link_allowin & ~flush;
   assign stall        = prod_readygo & prod_valid & ~link_allowin & ~flush;
   assign cons_signal  = mem[rd_ptr];
   assign occupancy    = count;
   assign rd_next      = pop ? PW'(ptr_inc(int'(rd_ptr), DEPTH)) : rd_ptr;
   assign wr_inc       = PW'(ptr_inc(int'(wr_ptr), DEPTH));

   // Flush keeps a same-cycle pop (that head already left) and clears validity only.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         rd_ptr <= rd_next;
         if (flush) begin
            wr_ptr <= rd_next;
            count  <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= prod_signal;
               wr_ptr      <= wr_inc;
            end
            count <= count + OW'(push) - OW'(pop);
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (stall),
      .count  (stall_cnt)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
      !(push && (count == FULL) && !pop));

endmodule

// File: tb/tb_pipe_link.sv
// Scoreboard bench for pipe_link: three differently configured instances share
// one stimulus stream, and each has its own queue-based reference model.
module tb_pipe_link;

   localparam int W     = 16;
   localparam int CNT_W = 4;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic         clk;
   logic         resetn;
   logic         flush;
   logic         prod_readygo;
   logic         prod_valid;
   logic [W-1:0] prod_signal;
   logic         cons_pop;

   int assertions;
   int failures;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Lane g: 0 = depth 2 with registered allowin, 1 = depth 3 bypassed, 2 = depth 1 bypassed.
   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int D  = (g == 0) ? 2 : (g == 1) ? 3 : 1;
      localparam int AR = (g == 0) ? 1 : 0;
      localparam int OW = $clog2(D + 1);

      logic               allowin;
      logic               cvalid;
      logic [W-1:0]       csig;
      logic [OW-1:0]      occ;
      logic [CNT_W-1:0]   scnt;

      logic [W-1:0] q[$];
      int           stall_m;

      pipe_link #(.WIDTH(W), .DEPTH(D), .ALLOWIN_REG(AR), .CNT_W(CNT_W)) dut (
         .clk          (clk),
         .resetn       (resetn),
         .flush        (flush),
         .prod_readygo (prod_readygo),
         .prod_valid   (prod_valid),
         .prod_signal  (prod_signal),
         .link_allowin (allowin),
         .cons_valid   (cvalid),
         .cons_signal  (csig),
         .cons_pop     (cons_pop),
         .occupancy    (occ),
         .stall_cnt    (scnt)
      );

      // Checks the state left by the last edge, then advances the model across the next one.
      always @(negedge clk) begin
         bit pop_m;
         bit allow_m;
         if (!resetn) begin
            checkOutput($sformatf("rst_valid%0d", g), 64'(cvalid), 64'd0);
            checkOutput($sformatf("rst_occ%0d", g), 64'(occ), 64'd0);
            checkOutput($sformatf("rst_sig%0d", g), 64'(csig), 64'd0);
            checkOutput($sformatf("rst_stall%0d", g), 64'(scnt), 64'd0);
            checkOutput($sformatf("rst_allowin%0d", g), 64'(allowin), 64'd0);
            q.delete();
            stall_m = 0;
         end else begin
            checkOutput($sformatf("occ%0d", g), 64'(occ), 64'(q.size()));
            checkOutput($sformatf("valid%0d", g), 64'(cvalid), 64'(q.size() != 0));
            if (cvalid && q.size() != 0)
               checkOutput($sformatf("head%0d", g), 64'(csig), 64'(q[0]));
            checkOutput($sformatf("stall%0d", g), 64'(scnt), 64'(stall_m));
            pop_m   = cons_pop && (q.size() != 0);
            allow_m = (q.size() < D) || ((AR == 0) && pop_m);
            checkOutput($sformatf("allowin%0d", g), 64'(allowin), 64'(allow_m));
            if (prod_readygo && prod_valid && !allow_m && !flush && stall_m < SAT)
               stall_m++;
            if (pop_m)
               void'(q.pop_front());
            if (flush)
               q.delete();
            else if (prod_readygo && prod_valid && allow_m)
               q.push_back(prod_signal);
         end
      end
   end

   task automatic applyStimulus(input bit rg, input bit v, input logic [W-1:0] sig,
                                input bit pop, input bit fl);
      @(posedge clk);
      #1;
      prod_readygo = rg;
      prod_valid   = v;
      prod_signal  = sig;
      cons_pop     = pop;
      flush        = fl;
   endtask

   initial begin
      assertions   = 0;
      failures     = 0;
      resetn       = 1'b0;
      flush        = 1'b0;
      prod_readygo = 1'b0;
      prod_valid   = 1'b0;
      prod_signal  = '0;
      cons_pop     = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      $display("[TB] fill and saturate stall counter");
      for (int i = 0; i < 25; i++) applyStimulus(1, 1, W'(16'h00A0 + i), 0, 0);
      applyStimulus(0, 0, '0, 0, 0);
      @(negedge clk);
      checkOutput("sat0", 64'(lane[0].scnt), 64'(SAT));
      checkOutput("sat1", 64'(lane[1].scnt), 64'(SAT));
      checkOutput("sat2", 64'(lane[2].scnt), 64'(SAT));

      $display("[TB] drain");
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0);

      $display("[TB] full push with pop");
      for (int i = 1; i <= 3; i++) applyStimulus(1, 1, W'(i), 0, 0);
      for (int i = 4; i <= 9; i++) applyStimulus(1, 1, W'(i), 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0);

      $display("[TB] flush with pop");
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, W'(16'h0010 + i), 0, 0);
      applyStimulus(1, 1, 16'h0013, 1, 1);
      applyStimulus(0, 0, '0, 0, 0);
      applyStimulus(0, 0, '0, 1, 0);

      $display("[TB] bubble filtering");
      applyStimulus(1, 1, 16'h0020, 0, 0);
      applyStimulus(1, 0, 16'h0021, 0, 0);
      applyStimulus(1, 1, 16'h0022, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++)
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                       W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));

      $display("[TB] async reset mid-operation");
      applyStimulus(0, 0, '0, 1, 1);
      applyStimulus(1, 1, 16'h0051, 0, 0);
      applyStimulus(1, 1, 16'h0052, 0, 0);
      applyStimulus(0, 0, '0, 0, 0);
      #2 resetn = 1'b0;
      #1;
      checkOutput("arst_valid", 64'({lane[0].cvalid, lane[1].cvalid, lane[2].cvalid}), 64'd0);
      checkOutput("arst_occ", 64'(lane[1].occ), 64'd0);
      checkOutput("arst_occ0", 64'(lane[0].occ), 64'd0);
      checkOutput("arst_stall", 64'(lane[0].scnt), 64'd0);
      checkOutput("arst_allowin", 64'({lane[0].allowin, lane[1].allowin, lane[2].allowin}), 64'd0);
      checkOutput("arst_sig", 64'(lane[1].csig), 64'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      applyStimulus(1, 1, 16'h0077, 0, 0);
      applyStimulus(0, 0, '0, 0, 0);
      @(negedge clk);
      checkOutput("post_rst_head", 64'(lane[1].csig), 64'h77);
      applyStimulus(0, 0, '0, 1, 0);
      repeat (3) applyStimulus(0, 0, '0, 0, 0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
